regfile_writeback: RTL

//  Write-side partner of the pipelined CPU register file; sole driver of its WE3/RA3/WD3 port.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/wb_fifo.sv | 51 +++++
 rtl/regfile_writeback.sv | 89 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the register-file writeback path.
package cpu_pkg;
   localparam int SIZE       = 32;
   localparam int AMOUNT_REG = 4;
   localparam logic [AMOUNT_REG-1:0] PC_REG = 4'b1111;

   typedef struct packed {
      logic [AMOUNT_REG-1:0] rd;
      logic [SIZE-1:0]       data;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO of writeback entries with two ordered push ports and one pop.
module wb_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic                                  CLK,
   input  logic                                  RESET,
   input  logic                                  push_a,
   input  wb_entry_t                             entry_a,
   input  logic                                  push_b,
   input  wb_entry_t                             entry_b,
   input  logic                                  pop,
   output wb_entry_t                             head,
   output logic [CW-1:0]                         count,
   output logic [DEPTH-1:0]                      vld,
   output logic [DEPTH-1:0][AMOUNT_REG-1:0]      rds
);
   wb_entry_t         mem [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [PW-1:0]     wr_ptr_b;

   // Port a is the older instruction, so port b lands behind it when both push.
   assign wr_ptr_b = wr_ptr + PW'(push_a);
   assign head     = mem[rd_ptr];

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push_a) mem[wr_ptr]   <= entry_a;
         if (push_b) mem[wr_ptr_b] <= entry_b;
         wr_ptr <= wr_ptr + PW'(push_a) + PW'(push_b);
         rd_ptr <= rd_ptr + PW'(pop);
         count  <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
      end
   end

   // An entry is live when its distance from the read pointer is below count.
   for (genvar i = 0; i < DEPTH; i++) begin : g_vld
      logic [PW-1:0] off;
      assign off    = PW'(i) - rd_ptr;
      assign vld[i] = {1'b0, off} < count;
      assign rds[i] = mem[i].rd;
   end
endmodule

// File: rtl/regfile_writeback.sv
// Sole writer of the regfile WE3/RA3/WD3 port; buffers ALU and load results in order.
module regfile_writeback
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  MEM_VALID,
   output logic                  MEM_READY,
   input  logic [AMOUNT_REG-1:0] MEM_RD,
   input  logic [SIZE-1:0]       MEM_DATA,
   input  logic                  ALU_VALID,
   output logic                  ALU_READY,
   input  logic [AMOUNT_REG-1:0] ALU_RD,
   input  logic [SIZE-1:0]       ALU_DATA,
   output logic                  WE3,
   output logic [AMOUNT_REG-1:0] RA3,
   output logic [SIZE-1:0]       WD3,
   output logic                  PC_WE,
   output logic [SIZE-1:0]       PC_WD,
   output logic [15:0]           PENDING,
   output logic                  IDLE
);
   localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

   logic                                  push_mem, push_alu, pop;
   wb_entry_t                             head;
   logic [CW-1:0]                         count;
   logic [DEPTH-1:0]                      vld;
   logic [DEPTH-1:0][AMOUNT_REG-1:0]      rds;

   // Readiness uses only registered count; no credit for a same-cycle pop.
   assign MEM_READY = count <= LAST;
   assign ALU_READY = (count + CW'(MEM_VALID)) <= LAST;
   assign push_mem  = MEM_VALID && MEM_READY;
   assign push_alu  = ALU_VALID && ALU_READY;
   assign pop       = count != '0;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .CLK     (CLK),
      .RESET   (RESET),
      .push_a  (push_mem),
      .entry_a ('{rd: MEM_RD, data: MEM_DATA}),
      .push_b  (push_alu),
      .entry_b ('{rd: ALU_RD, data: ALU_DATA}),
      .pop     (pop),
      .head    (head),
      .count   (count),
      .vld     (vld),
      .rds     (rds)
   );

   // R15 is the PC and never reaches the regfile port.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         WE3   <= 1'b0;
         RA3   <= '0;
         WD3   <= '0;
         PC_WE <= 1'b0;
         PC_WD <= '0;
      end else if (pop) begin
         if (head.rd == PC_REG) begin
            WE3   <= 1'b0;
            PC_WE <= 1'b1;
            PC_WD <= head.data;
         end else begin
            WE3   <= 1'b1;
            RA3   <= head.rd;
            WD3   <= head.data;
            PC_WE <= 1'b0;
         end
      end else begin
         WE3   <= 1'b0;
         PC_WE <= 1'b0;
      end
   end

   always_comb begin
      PENDING = '0;
      for (int i = 0; i < DEPTH; i++)
         if (vld[i]) PENDING[rds[i]] = 1'b1;
      if (WE3)   PENDING[RA3]    = 1'b1;
      if (PC_WE) PENDING[PC_REG] = 1'b1;
   end

   assign IDLE = (count == '0) && !WE3 && !PC_WE;
endmodule
